// File: rtl/datapath_seq_pkg.sv
// ---------------------------------------------------------------------------
// datapath_seq_pkg
// Shared types and constants for the nibble datapath sequencer.
//   seq_state_t : frame-level FSM states
//   sel_cfg_t   : every MUX/DEMUX select driven by the sequencer, packed
//   PROFILE     : select values for each of the four routing modes
// No ports (package).
// ---------------------------------------------------------------------------
package datapath_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONFIG,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

    typedef struct packed {
        logic [2:0] sel1;
        logic [2:0] sel2;
        logic       sel3;
        logic [1:0] sel6;
        logic [1:0] sel9;
        logic       sel11;
        logic       sel12;
        logic [2:0] sel15;
        logic       sel17;
    } sel_cfg_t;

    localparam sel_cfg_t PROF_BYPASS = '0;

    localparam sel_cfg_t PROF_TX = '{
        sel1: 3'd1, sel2: 3'd1, sel3: 1'b1, sel6: 2'd1, sel9: 2'd1,
        sel11: 1'b0, sel12: 1'b1, sel15: 3'd1, sel17: 1'b0
    };

    localparam sel_cfg_t PROF_RX = '{
        sel1: 3'd2, sel2: 3'd2, sel3: 1'b0, sel6: 2'd2, sel9: 2'd2,
        sel11: 1'b1, sel12: 1'b0, sel15: 3'd2, sel17: 1'b1
    };

    localparam sel_cfg_t PROF_LOOP = '{
        sel1: 3'd3, sel2: 3'd3, sel3: 1'b1, sel6: 2'd3, sel9: 2'd3,
        sel11: 1'b1, sel12: 1'b1, sel15: 3'd3, sel17: 1'b1
    };

    // Indexed directly by the 2-bit routing mode.
    localparam sel_cfg_t [3:0] PROFILE = {PROF_LOOP, PROF_RX, PROF_TX, PROF_BYPASS};

endpackage

// File: rtl/seq_valid_delay.sv
// ---------------------------------------------------------------------------
// seq_valid_delay
// Models the datapath latency for the write strobe: a DEPTH-deep 1-bit shift
// register, so every pop reappears as a push exactly DEPTH cycles later.
//   clk     : clock
//   rst_n   : asynchronous active-low clear
//   strobe  : input-FIFO pop strobe
//   delayed : strobe delayed DEPTH cycles (output-FIFO push)
//   pending : at least one strobe still travelling through the line
// ---------------------------------------------------------------------------
module seq_valid_delay #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic delayed,
    output logic pending
);

    logic [DEPTH-1:0] taps;

    // Shift written as shift-or so that DEPTH=1 needs no special case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps <= '0;
        end else begin
            taps <= (taps << 1) | DEPTH'(strobe);
        end
    end

    assign delayed = taps[DEPTH-1];
    assign pending = |taps;

endmodule

// File: rtl/datapath_sequencer.sv
// ---------------------------------------------------------------------------
// datapath_sequencer
// Frame controller for the nibble datapath between the input and output FIFOs.
// On start it latches a routing profile and a frame length, drives all
// MUX/DEMUX selects, pops exactly frame-length nibbles and lets the matching
// output-FIFO pushes emerge after the pipeline latency.
//
// Optional feature: define SEQ_TIMEOUT_EN to add a stall watchdog that gives up
// on the frame after TIMEOUT_CYCLES pop-less RUN cycles and raises outError.
//
// Ports
//   inClock, inReset       : clock, asynchronous active-low reset
//   inStart                : frame request (only honoured in IDLE)
//   inMode, inFrameLen     : routing profile and nibble count (0 legal)
//   inFifoEmpty            : input FIFO empty
//   inOutFifoAfull         : output FIFO cannot absorb another pipeline load
//   outReadEnable          : input-FIFO pop
//   outWriteEnable         : output-FIFO push
//   outSEL1..outSEL17      : datapath selects
//   outBusy, outDone       : frame in progress / one-cycle end-of-frame pulse
//   outError               : sticky timeout flag (0 without SEQ_TIMEOUT_EN)
// ---------------------------------------------------------------------------
module datapath_sequencer
    import datapath_seq_pkg::*;
#(
    parameter int LEN_W          = 8,
    parameter int SETTLE_CYCLES  = 2,
    parameter int PIPE_LAT       = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             inClock,
    input  logic             inReset,
    input  logic             inStart,
    input  logic [1:0]       inMode,
    input  logic [LEN_W-1:0] inFrameLen,
    input  logic             inFifoEmpty,
    input  logic             inOutFifoAfull,
    output logic             outReadEnable,
    output logic             outWriteEnable,
    output logic [2:0]       outSEL1,
    output logic [2:0]       outSEL2,
    output logic             outSEL3,
    output logic [1:0]       outSEL6,
    output logic [1:0]       outSEL9,
    output logic             outSEL11,
    output logic             outSEL12,
    output logic [2:0]       outSEL15,
    output logic             outSEL17,
    output logic             outBusy,
    output logic             outDone,
    output logic             outError
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    seq_state_t       state;
    seq_state_t       next_state;
    sel_cfg_t         sel_reg;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] pop_cnt;
    logic [SET_W-1:0] settle_cnt;
    logic             start_accept;
    logic             settle_last;
    logic             read_en;
    logic             write_en;
    logic             pending;
    logic             timeout_hit;
    logic             error_flag;

    assign start_accept = (state == ST_IDLE) && inStart;
    assign settle_last  = (settle_cnt == SET_W'(SETTLE_CYCLES - 1));

    // Pop whenever data is there and the output side can absorb a full
    // pipeline load; the length check keeps a frame from over-reading.
    assign read_en = (state == ST_RUN) && !inFifoEmpty && !inOutFifoAfull
                     && (pop_cnt < len_reg);

    // State register.
    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (inStart) begin
                    next_state = ST_CONFIG;
                end
            end
            ST_CONFIG: begin
                if (settle_last) begin
                    next_state = (len_reg == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (read_en && (pop_cnt == len_reg - LEN_W'(1))) begin
                    next_state = ST_DRAIN;
                end else if (timeout_hit) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!pending) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Frame parameters and counters. Selects are only loaded on an accepted
    // start, so they stay stable for the frame and hold the last profile in IDLE.
    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            sel_reg    <= '0;
            len_reg    <= '0;
            pop_cnt    <= '0;
            settle_cnt <= '0;
        end else if (start_accept) begin
            sel_reg    <= PROFILE[inMode];
            len_reg    <= inFrameLen;
            pop_cnt    <= '0;
            settle_cnt <= '0;
        end else begin
            if (state == ST_CONFIG) begin
                settle_cnt <= settle_cnt + SET_W'(1);
            end
            if (read_en) begin
                pop_cnt <= pop_cnt + LEN_W'(1);
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [STALL_W-1:0] stall_cnt;

    assign timeout_hit = (state == ST_RUN) && !read_en
                         && (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

    // Stall watchdog: counts consecutive pop-less RUN cycles. The error flag
    // survives DONE and is only cleared by the next accepted start.
    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            stall_cnt  <= '0;
            error_flag <= 1'b0;
        end else if (start_accept) begin
            stall_cnt  <= '0;
            error_flag <= 1'b0;
        end else if (state == ST_RUN) begin
            if (read_en) begin
                stall_cnt <= '0;
            end else if (timeout_hit) begin
                stall_cnt  <= '0;
                error_flag <= 1'b1;
            end else begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign error_flag  = 1'b0;
`endif

    seq_valid_delay #(
        .DEPTH (PIPE_LAT)
    ) u_valid_delay (
        .clk     (inClock),
        .rst_n   (inReset),
        .strobe  (read_en),
        .delayed (write_en),
        .pending (pending)
    );

    assign outReadEnable  = read_en;
    assign outWriteEnable = write_en;
    assign outBusy        = (state != ST_IDLE);
    assign outDone        = (state == ST_DONE);
    assign outError       = error_flag;

    assign outSEL1  = sel_reg.sel1;
    assign outSEL2  = sel_reg.sel2;
    assign outSEL3  = sel_reg.sel3;
    assign outSEL6  = sel_reg.sel6;
    assign outSEL9  = sel_reg.sel9;
    assign outSEL11 = sel_reg.sel11;
    assign outSEL12 = sel_reg.sel12;
    assign outSEL15 = sel_reg.sel15;
    assign outSEL17 = sel_reg.sel17;

endmodule
